lk_window_grad_accum: RTL and testbench
=======================================

Name: lk_window_grad_accum

Overview:
Downstream consumer of the two-row window FIFO in the pyramidal LK datapath. Takes one column per cycle from two consecutive rows of frame I, plus the co-located frame-J pixel. Computes spatial and temporal gradients per pixel and accumulates the LK normal-equation terms Gxx, Gyy, Gxy, bx, by over a WIN x WIN window. Hands the finished sums to the flow solver with a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 8, pixel width (unsigned)
WIN, 7, window edge in gradient samples; each row consumes WIN+1 input columns
ACC_W, 2*DATA_WIDTH+2+$clog2(WIN*WIN), signed accumulator/output width (24 at defaults; cannot overflow)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
win_start  in  1  one-cycle pulse; clears accumulators/counters, arms a new window
in_valid  in  1  column sample valid; no backpressure
i_row0  in  DATA_WIDTH  frame-I pixel, window row r
i_row1  in  DATA_WIDTH  frame-I pixel, row r+1, same column
j_row0  in  DATA_WIDTH  frame-J pixel co-located with i_row0
gxx, gyy, gxy  out  ACC_W  signed sums of Ix*Ix, Iy*Iy, Ix*Iy
bx, by  out  ACC_W  signed sums of Ix*It, Iy*It (negation done downstream)
out_valid  out  1  one-cycle pulse, sums final
busy  out  1  high from win_start until out_valid

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs, accumulators, counters, pipeline registers = 0.
- States: IDLE -> ACCUM on win_start; ACCUM -> DRAIN after the last sample (row_cnt=WIN-1, col_cnt=WIN) is accepted; DRAIN lasts 3 cycles -> DONE; DONE lasts 1 cycle (out_valid=1) -> IDLE.
- busy=1 in ACCUM and DRAIN; 0 in IDLE and DONE.
- in_valid is ignored in IDLE, DRAIN and DONE.
- win_start in any state: restarts ACCUM with zeroed accumulators and counters. Pipeline stage-valid bits are flushed. A partially accumulated window is discarded; no out_valid is produced for it.
- Counters advance only on accepted samples (ACCUM & in_valid); gaps in in_valid are allowed.
  - col_cnt counts 0..WIN; on wrap, row_cnt counts 0..WIN-1.
- Stage 0 (accept):
  - col_cnt=0: only stores i_row0 into prev0; no gradient is emitted.
  - col_cnt>0: emits a gradient sample and updates prev0.
- Stage 1 (registered, 9-bit signed, zero-extended operands):
  - Ix = i_row0 - prev0
  - Iy = i_row1 - i_row0
  - It = j_row0 - i_row0
- Stage 2 (registered): five 2*(DATA_WIDTH+1)-bit signed products.
- Stage 3: products sign-extended to ACC_W and added into accumulators; a stage-valid bit travels with each sample.
- Latency: last sample accepted at cycle T -> accumulators final at T+3 -> out_valid=1 and outputs updated at T+4.
- Outputs hold until the next out_valid or reset. Outputs are not cleared by win_start.
- Exactly WIN*WIN products are accumulated per window.

Optional Feature:
LK_DET_EN: defined -> adds output det (2*ACC_W+1 bits, signed) = gxx*gyy - gxy*gxy, computed in one extra registered stage. With it defined:
- out_valid moves to T+5.
- DONE is entered one cycle later.
- det resets to 0.
Undefined -> no det port; timing as above.

Test Plan:
- Reset mid-ACCUM: drive rst=0 after 10 samples -> all outputs 0, busy=0; a following full window gives correct sums.
- Flat image: i_row0=i_row1=j_row0=100 for all 56 samples (WIN=7) -> gxx=gyy=gxy=bx=by=0; out_valid exactly once, at T+4.
- Horizontal ramp plus temporal step: i_row0=i_row1=2*col, j_row0=i_row0+1 -> gxx=196, gyy=0, gxy=0, bx=98, by=0.
- Vertical step with negative It: i_row0=50, i_row1=53, j_row0=48 -> gyy=441, by=-294, gxx=gxy=bx=0.
- Gapped input: in_valid toggled every other cycle with the ramp stimulus -> same sums as the contiguous case; out_valid 4 cycles after the last accepted sample.
- Abort/restart: win_start after 20 samples, then a full flat window -> only one out_valid, all sums 0. With LK_DET_EN, ramp case -> det=0 and out_valid at T+5.

Source files
------------

// File: rtl/lk_window_grad_accum.sv
// lk_window_grad_accum: per-pixel LK gradients (Ix, Iy, It) and WIN x WIN
// accumulation of the normal-equation terms Gxx, Gyy, Gxy, bx, by.
// Ports:
//   clk, rst (async, active-low)
//   win_start     : one-cycle pulse, clears accumulators and arms a new window
//   in_valid      : column sample valid (no backpressure)
//   i_row0/i_row1 : frame-I pixels of rows r and r+1, same column
//   j_row0        : frame-J pixel co-located with i_row0
//   gxx..by       : signed window sums, updated with out_valid
//   det           : gxx*gyy - gxy*gxy (only when LK_DET_EN is defined)
//   out_valid     : one-cycle pulse, sums final
//   busy          : high from win_start until out_valid
// Optional feature macro: LK_DET_EN (adds det, one extra cycle of latency).
module lk_window_grad_accum #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WIN        = 7,
    parameter int unsigned ACC_W      = 2*DATA_WIDTH + 2 + $clog2(WIN*WIN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         win_start,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        i_row0,
    input  logic [DATA_WIDTH-1:0]        i_row1,
    input  logic [DATA_WIDTH-1:0]        j_row0,
    output logic signed [ACC_W-1:0]      gxx,
    output logic signed [ACC_W-1:0]      gyy,
    output logic signed [ACC_W-1:0]      gxy,
    output logic signed [ACC_W-1:0]      bx,
    output logic signed [ACC_W-1:0]      by,
`ifdef LK_DET_EN
    output logic signed [2*ACC_W:0]      det,
`endif
    output logic                         out_valid,
    output logic                         busy
);

    localparam int unsigned GW  = DATA_WIDTH + 1;
    localparam int unsigned PW  = 2 * GW;
    localparam int unsigned CW  = $clog2(WIN + 1);
    localparam int unsigned RW  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned DCW = 3;
`ifdef LK_DET_EN
    localparam int unsigned DW        = 2*ACC_W + 1;
    localparam int unsigned DRAIN_CYC = 4;
`else
    localparam int unsigned DRAIN_CYC = 3;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                 state, next_state;
    logic [CW-1:0]          col_cnt;
    logic [RW-1:0]          row_cnt;
    logic [DCW-1:0]         drain_cnt;
    logic [DATA_WIDTH-1:0]  prev0;
    logic                   accept_c, last_c, load_c;

    logic                   s1_vld, s2_vld;
    logic signed [GW-1:0]   ix, iy, it;
    logic signed [PW-1:0]   p_xx, p_yy, p_xy, p_xt, p_yt;
    logic signed [ACC_W-1:0] acc_xx, acc_yy, acc_xy, acc_xt, acc_yt;
`ifdef LK_DET_EN
    logic signed [DW-1:0]   det_pipe;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next state, sample acceptance and output load strobe; win_start overrides all
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        load_c     = 1'b0;
        last_c     = (row_cnt == RW'(WIN - 1)) && (col_cnt == CW'(WIN));
        case (state)
            IDLE:  next_state = IDLE;
            ACCUM: begin
                accept_c = in_valid;
                if (in_valid && last_c) next_state = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == DCW'(DRAIN_CYC - 1)) begin
                    next_state = DONE;
                    load_c     = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (win_start) begin
            next_state = ACCUM;
            accept_c   = 1'b0;
            load_c     = 1'b0;
        end
    end

    // Column/row position within the window and drain timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            if (win_start) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (accept_c) begin
                if (col_cnt == CW'(WIN)) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == RW'(WIN - 1)) ? '0 : row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
            drain_cnt <= (state == DRAIN && !win_start) ? drain_cnt + DCW'(1) : '0;
        end
    end

    // Gradient, product and accumulate pipeline; column 0 only primes prev0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev0  <= '0;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            ix     <= '0;
            iy     <= '0;
            it     <= '0;
            p_xx   <= '0;
            p_yy   <= '0;
            p_xy   <= '0;
            p_xt   <= '0;
            p_yt   <= '0;
            acc_xx <= '0;
            acc_yy <= '0;
            acc_xy <= '0;
            acc_xt <= '0;
            acc_yt <= '0;
        end else begin
            if (accept_c) begin
                prev0 <= i_row0;
                ix    <= $signed({1'b0, i_row0}) - $signed({1'b0, prev0});
                iy    <= $signed({1'b0, i_row1}) - $signed({1'b0, i_row0});
                it    <= $signed({1'b0, j_row0}) - $signed({1'b0, i_row0});
            end
            s1_vld <= accept_c && (col_cnt != '0);
            s2_vld <= s1_vld && !win_start;
            if (s1_vld) begin
                p_xx <= PW'(ix) * PW'(ix);
                p_yy <= PW'(iy) * PW'(iy);
                p_xy <= PW'(ix) * PW'(iy);
                p_xt <= PW'(ix) * PW'(it);
                p_yt <= PW'(iy) * PW'(it);
            end
            if (win_start) begin
                acc_xx <= '0;
                acc_yy <= '0;
                acc_xy <= '0;
                acc_xt <= '0;
                acc_yt <= '0;
            end else if (s2_vld) begin
                acc_xx <= acc_xx + ACC_W'(p_xx);
                acc_yy <= acc_yy + ACC_W'(p_yy);
                acc_xy <= acc_xy + ACC_W'(p_xy);
                acc_xt <= acc_xt + ACC_W'(p_xt);
                acc_yt <= acc_yt + ACC_W'(p_yt);
            end
        end
    end

    // Output registers: hold until the next completed window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gxx       <= '0;
            gyy       <= '0;
            gxy       <= '0;
            bx        <= '0;
            by        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= (next_state == DONE);
            busy      <= (next_state == ACCUM) || (next_state == DRAIN);
            if (load_c) begin
                gxx <= acc_xx;
                gyy <= acc_yy;
                gxy <= acc_xy;
                bx  <= acc_xt;
                by  <= acc_yt;
            end
        end
    end

`ifdef LK_DET_EN
    // Determinant tracks the accumulators one cycle behind; captured on load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_pipe <= '0;
            det      <= '0;
        end else begin
            det_pipe <= DW'(acc_xx) * DW'(acc_yy) - DW'(acc_xy) * DW'(acc_xy);
            if (load_c) det <= det_pipe;
        end
    end
`endif

endmodule

// File: tb/tb_lk_window_grad_accum.sv
// Bench for lk_window_grad_accum: table of synthetic image patterns with
// hand-derived window sums, scoreboard-checked on out_valid, plus reset and
// abort/restart sequences.
module tb_lk_window_grad_accum;

    localparam int DATA_WIDTH = 8;
    localparam int WIN        = 7;
    localparam int ACC_W      = 24;
    localparam int FULL       = WIN * (WIN + 1);
`ifdef LK_DET_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    logic win_start, in_valid;
    logic [DATA_WIDTH-1:0] i_row0, i_row1, j_row0;
    logic signed [ACC_W-1:0] gxx, gyy, gxy, bx, by;
`ifdef LK_DET_EN
    logic signed [2*ACC_W:0] det;
`endif
    logic out_valid, busy;

    lk_window_grad_accum #(.DATA_WIDTH(DATA_WIDTH), .WIN(WIN)) dut (
        .clk(clk), .rst(rst), .win_start(win_start), .in_valid(in_valid),
        .i_row0(i_row0), .i_row1(i_row1), .j_row0(j_row0),
        .gxx(gxx), .gyy(gyy), .gxy(gxy), .bx(bx), .by(by),
`ifdef LK_DET_EN
        .det(det),
`endif
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     kind;
        bit     gapped;
        longint gxx, gyy, gxy, bx, by;
        int     cyc;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[7];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synthetic patterns; every kind has constant gradients within a row
    function automatic void pix(input int kind, input int row, input int col,
                                output logic [7:0] a, output logic [7:0] b, output logic [7:0] c);
        int x0, x1, xj;
        case (kind)
            1:       begin x0 = 2*col;                 x1 = x0;     xj = x0 + 1;   end
            2:       begin x0 = 50;                    x1 = 53;     xj = 48;       end
            3:       begin x0 = 10 + 3*col + row;      x1 = x0 + 5; xj = x0 - 4;   end
            4:       begin x0 = 200 - 5*col;           x1 = x0 - 7; xj = x0 + 2;   end
            5:       begin x0 = (col % 2 == 0) ? 255 : 0; x1 = x0;  xj = 255 - x0; end
            default: begin x0 = 100;                   x1 = 100;    xj = 100;      end
        endcase
        a = 8'(x0);
        b = 8'(x1);
        c = 8'(xj);
    endfunction

    // Starts a window, feeds nsamp samples; a full window is scoreboarded and
    // its completion timing checked while garbage is offered on in_valid.
    task automatic drive_window(input int nsamp, input vec_t v);
        logic [7:0] a, b, c;
        vec_t e;
        win_start = 1'b1;
        in_valid  = 1'b0;
        tick();
        win_start = 1'b0;
        for (int s = 0; s < nsamp; s++) begin
            if (v.gapped && s > 0) begin
                in_valid = 1'b0;
                i_row0 = 8'($urandom); i_row1 = 8'($urandom); j_row0 = 8'($urandom);
                tick();
            end
            pix(v.kind, s / (WIN + 1), s % (WIN + 1), a, b, c);
            i_row0 = a; i_row1 = b; j_row0 = c;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (nsamp == FULL) begin
            e = v;
            e.cyc = cyc + LAT - 1;
            sb.push_back(e);
            for (int k = 0; k < LAT - 2; k++) begin
                in_valid = 1'b1;
                i_row0 = 8'($urandom); i_row1 = 8'($urandom); j_row0 = 8'($urandom);
                tick();
                check("early_out_valid", longint'(out_valid), 0);
                check("drain_busy", longint'(busy), 1);
            end
            tick();
            check("out_valid_pulse", longint'(out_valid), 1);
            check("busy_done", longint'(busy), 0);
            tick();
            check("out_valid_single", longint'(out_valid), 0);
            in_valid = 1'b0;
        end
    endtask

    // Scoreboard: every out_valid must match the oldest pending window
    always @(posedge clk) begin
        vec_t e;
        #1;
        if (rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_cycle", longint'(cyc), longint'(e.cyc));
                check("gxx", longint'(gxx), e.gxx);
                check("gyy", longint'(gyy), e.gyy);
                check("gxy", longint'(gxy), e.gxy);
                check("bx",  longint'(bx),  e.bx);
                check("by",  longint'(by),  e.by);
`ifdef LK_DET_EN
                check("det", longint'(det), e.gxx*e.gyy - e.gxy*e.gxy);
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        vec_t ramp, flat;
        //           kind gap  gxx      gyy   gxy   bx        by   cyc
        tbl[0] = '{0, 0, 0,       0,    0,    0,        0,    0};
        tbl[1] = '{1, 0, 196,     0,    0,    98,       0,    0};
        tbl[2] = '{2, 0, 0,       441,  0,    0,        -294, 0};
        tbl[3] = '{1, 1, 196,     0,    0,    98,       0,    0};
        tbl[4] = '{3, 0, 441,     1225, 735,  -588,     -980, 0};
        tbl[5] = '{4, 1, 1225,    2401, 1715, -490,     -686, 0};
        tbl[6] = '{5, 0, 3186225, 0,    0,    -3186225, 0,    0};
        ramp = tbl[1];
        flat = tbl[0];

        rst = 1'b0; win_start = 1'b0; in_valid = 1'b0;
        i_row0 = '0; i_row1 = '0; j_row0 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gxx", longint'(gxx), 0);
        check("rst_bx", longint'(bx), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) drive_window(FULL, tbl[i]);

        // Reset in the middle of a window, then a clean ramp window
        drive_window(10, tbl[4]);
        check("mid_busy_before_rst", longint'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_gxx", longint'(gxx), 0);
        check("mid_rst_gyy", longint'(gyy), 0);
        check("mid_rst_gxy", longint'(gxy), 0);
        check("mid_rst_bx", longint'(bx), 0);
        check("mid_rst_by", longint'(by), 0);
        check("mid_rst_busy", longint'(busy), 0);
        tick();
        rst = 1'b1;
        tick();
        drive_window(FULL, ramp);

        // Abort after 20 samples of a non-flat window, restart with a flat one
        drive_window(20, tbl[6]);
        drive_window(FULL, flat);

        repeat (LAT + 2) tick();
        check("scoreboard_empty", longint'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
